// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard-lamp line: display modes and pattern constants.
// Also imported by the control-station top, so keep it free of per-instance parameters.
package hazard_pkg;

    typedef enum logic [1:0] {
        MODE_CALM   = 2'b00,
        MODE_RTL    = 2'b01,
        MODE_LTR    = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    localparam int N_LEDS_MIN = 2;
    localparam int N_LEDS_MAX = 32;

    // Widest even-bit lamp pattern; narrower lines take the low bits.
    localparam logic [N_LEDS_MAX-1:0] CALM_EVEN_FULL = 32'h5555_5555;

    function automatic logic is_sweep(input mode_t m);
        return (m == MODE_RTL) || (m == MODE_LTR);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Run-time programmable divider: one tick every max(div,1) enabled cycles.
// Lowering div below the running count fires on the next cycle instead of wrapping.
module tick_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // div of 0 behaves as 1, so the terminal count is 0 in both cases.
    always_comb begin
        last = (div == '0) ? '0 : div - DIV_W'(1);
    end

    // Comparing with >= rather than == lets a shrunken divisor fire at once.
    assign tick = en && !reset && (cnt >= last);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/hazard_sweep.sv
// Hazard lamp line: calm alternation or a single lamp sweeping either way,
// advanced by a programmable prescaler and frozen in place on request.
module hazard_sweep
    import hazard_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  tick_div,
    output logic [N_LEDS-1:0] led,
    output logic              step,
    output logic [1:0]        cur_mode
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] EVEN_MASK = CALM_EVEN_FULL[N_LEDS-1:0];
    localparam logic [N_LEDS-1:0] ODD_MASK  = ~EVEN_MASK;
    localparam logic [N_LEDS-1:0] LAMP_LOW  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LAMP_HIGH = LAMP_LOW << (N_LEDS - 1);

    mode_t            req_mode;
    mode_t            disp_mode;
    mode_t            disp_next;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_next;
    logic             tick;

    assign req_mode = mode_t'(mode);

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (req_mode != MODE_FREEZE),
        .div   (tick_div),
        .tick  (tick)
    );

    assign step     = tick;
    assign cur_mode = disp_mode;

    // A tick never occurs in FREEZE, so disp_mode can never take that value.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        disp_next = disp_mode;
        pos_next  = pos;
        if (tick) begin
            if (req_mode != disp_mode) begin
                disp_next = req_mode;
                pos_next  = '0;
            end else if (is_sweep(disp_mode)) begin
                pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end else if (disp_mode == MODE_CALM) begin
                pos_next = (pos == '0) ? POS_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_mode <= MODE_CALM;
            pos       <= '0;
        end else begin
            disp_mode <= disp_next;
            pos       <= pos_next;
        end
    end

    // Moore decode: the lamps follow the registered state only.
    always_comb begin
        led = EVEN_MASK;
        unique case (disp_mode)
            MODE_CALM: led = pos[0] ? ODD_MASK : EVEN_MASK;
            MODE_RTL:  led = LAMP_LOW << pos;
            MODE_LTR:  led = LAMP_HIGH >> pos;
            default:   led = EVEN_MASK;
        endcase
    end

endmodule

// File: doc/hazard_sweep.md
HAZARD_SWEEP -- requirements
Module: hazard_sweep

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of lamps in the line (legal range 2..32).
REQ-002 SHALL have parameter DIV_W, default 24, width of the run-time tick divider.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port mode, input, 2, requested mode: 00 CALM, 01 RTL, 10 LTR, 11 FREEZE.
REQ-006 SHALL have port tick_div, input, DIV_W, clk cycles per pattern step; value 0 is treated as 1.
REQ-007 SHALL have port led, output, N_LEDS, lamp drive; bit 0 is the rightmost lamp.
REQ-008 SHALL have port step, output, 1, one-cycle pulse on each cycle in which a pattern tick occurs.
REQ-009 SHALL have port cur_mode, output, 2, currently displayed mode; it is never 11.

Function
REQ-010 SHALL use eff_div = max(tick_div,1); div_cnt counts 0..eff_div-1; tick is asserted when div_cnt >= eff_div-1 and mode != FREEZE.
REQ-011 On a tick, div_cnt SHALL return to 0; otherwise, if mode != FREEZE, div_cnt SHALL increment; in FREEZE, div_cnt SHALL hold.
REQ-012 If tick_div is lowered below the current div_cnt, a tick SHALL occur on the very next evaluated cycle, with no wrap through 2^DIV_W.
REQ-013 State SHALL be cur_mode plus pos, where pos has width $clog2(N_LEDS).
REQ-014 On a tick with mode != cur_mode, cur_mode SHALL take the value of mode and pos SHALL be set to 0 (the new pattern restarts at phase 0).
REQ-015 On a tick with mode == cur_mode in CALM, pos SHALL toggle between 0 and 1.
REQ-016 On a tick with mode == cur_mode in RTL or LTR, pos SHALL increment and wrap from N_LEDS-1 to 0.
REQ-017 FREEZE SHALL hold led, pos, cur_mode and div_cnt. On exit to the same mode, the sequence SHALL resume where it stopped. On exit to a different mode, REQ-014 SHALL apply at the next tick.
REQ-018 led SHALL be a Moore function of (cur_mode, pos):
- CALM pos 0: all even bits set.
- CALM pos 1: all odd bits set.
- RTL: only bit pos set (the lit lamp moves right to left).
- LTR: only bit N_LEDS-1-pos set (the lit lamp moves left to right).
REQ-019 led SHALL change on the clk edge that samples step=1, so the visible step latency is exactly one cycle after the step pulse.
REQ-020 step SHALL be combinational from the tick condition, and SHALL be 0 throughout FREEZE.
REQ-021 Changes to mode between ticks SHALL have no effect until the next tick; only the value at the tick is used.

Reset
REQ-022 Reset SHALL asynchronously set cur_mode to CALM, pos to 0 and div_cnt to 0; consequently led shows the even-bit pattern (0x55 for N_LEDS=8) and step=0.
REQ-023 Reset asserted mid-sweep SHALL take effect immediately, without waiting for a clk edge. After deassertion, the first tick SHALL occur eff_div cycles later.

Structure
REQ-024 The mode_t enum (MODE_CALM, MODE_RTL, MODE_LTR, MODE_FREEZE) SHALL live in the shared package hazard_pkg, which is also used by the control-station top.
REQ-025 The divider SHALL be a sub-module tick_prescaler with parameter DIV_W and ports clk, reset, en, div, tick.
REQ-026 Pattern decode SHALL be a pure combinational block with no latches, and SHALL have a default branch that drives the CALM pos 0 pattern.

Verification
REQ-027 Reset with N_LEDS=8, tick_div=3, mode=00 -> led=0x55, then alternates 0xAA/0x55 every 3 cycles, with step high 1 cycle in 3.
REQ-028 mode=01, tick_div=1 -> led sequence 0x01,0x02,...,0x80,0x01 (wrap), with step high every cycle.
REQ-029 In RTL at led=0x08, set mode=10 -> at the next tick led=0x80, then 0x40, 0x20; cur_mode=10.
REQ-030 In LTR at led=0x20, set mode=11 for 10 cycles, then back to 10 -> led holds 0x20 with step=0 throughout, then resumes with 0x10.
REQ-031 With tick_div=100 and div_cnt=50, set tick_div=10 -> tick on the next cycle; with tick_div=0 -> a tick every cycle.
REQ-032 Assert reset asynchronously, between clk edges, during an RTL sweep -> led=0x55 and cur_mode=00 before the next clk edge; the first step pulse comes tick_div cycles after release.
